axis_spi_cfg_master: RTL

SPI mode-0 (CPOL=0, CPHA=0) transmitting master that writes configuration/register words to the external ADC over its SDO line. Each word accepted on an AXI-Stream slave port is shifted out MSB-first under one CSn frame. The word simultaneously clocked back on SDI lane 0 is returned on an AXI-Stream master port for register readback. It sits beside the ADC sample-capture path and drives the same CSn/SCLK/SDO pins while that path is idle.

---
 rtl/axis_spi_cfg_master.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/axis_spi_cfg_master.sv
// -----------------------------------------------------------------------------
// axis_spi_cfg_master
//
// SPI mode-0 (CPOL=0, CPHA=0) configuration master for the external ADC.
// Each word accepted on the AXI-Stream slave port is shifted out MSB-first on
// spi_sdo under one CSn frame. The word clocked back on spi_sdi during that
// frame is returned on the AXI-Stream master port for register readback.
//
// Ports:
//   aclk, aresetn     system clock (rising edge) and async active-low reset
//   s_axis_t*         word to transmit (tdata/tvalid in, tready out)
//   m_axis_t*         readback word captured from spi_sdi (tdata/tvalid out,
//                     tready in)
//   spi_sdi           ADC serial data out (SDI lane 0)
//   spi_sdo           serial data to the ADC
//   spi_csn           chip select, active low
//   spi_clk           SCLK, a registered divider output (not a clock net)
//   busy              high from word acceptance until the FSM is back in IDLE
//
// Handshake semantics (both AXI-Stream ports): a transfer happens on a rising
// aclk edge where tvalid and tready are both high. A source holds tvalid and
// tdata stable until that transfer; a sink may drive tready freely. Here
// s_axis_tready is the only combinational output and depends only on local
// state, never on s_axis_tvalid.
//
// Frame timing, in aclk cycles with CSn low:
//   CS_SETUP  (SCLK low)
//   DATA_WIDTH bits of 2*CLK_DIV cycles each (CLK_DIV low, then CLK_DIV high)
//   CS_HOLD   (SCLK low)
// followed by CS_IDLE cycles with CSn high before the FSM returns to IDLE.
// -----------------------------------------------------------------------------
module axis_spi_cfg_master #(
  parameter int DATA_WIDTH = 24,
  parameter int CLK_DIV    = 4,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2,
  parameter int CS_IDLE    = 2
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic                  spi_sdi,
  output logic                  spi_sdo,
  output logic                  spi_csn,
  output logic                  spi_clk,
  output logic                  busy
);

  // One counter serves the setup, divider, hold and gap phases, so it is sized
  // for the largest of those terminal counts.
  localparam int MAX_SH  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int MAX_ID  = (CS_IDLE > CLK_DIV) ? CS_IDLE : CLK_DIV;
  localparam int CNT_MAX = (MAX_SH > MAX_ID) ? MAX_SH : MAX_ID;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(DATA_WIDTH);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(CS_IDLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_WIDTH - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  logic [2:0]            state_q,    state_d;
  logic [CNT_W-1:0]      cnt_q,      cnt_d;
  logic [BIT_W-1:0]      bit_q,      bit_d;
  logic [DATA_WIDTH-1:0] tx_q,       tx_d;
  logic [DATA_WIDTH-1:0] rx_q,       rx_d;
  logic [DATA_WIDTH-1:0] m_tdata_q,  m_tdata_d;
  logic                  m_tvalid_q, m_tvalid_d;
  logic                  sdo_q,      sdo_d;
  logic                  csn_q,      csn_d;
  logic                  sclk_q,     sclk_d;
  logic                  busy_q,     busy_d;

  logic                  s_hs;

  // Holding off acceptance while a readback is pending guarantees the
  // readback register is never overwritten.
  assign s_axis_tready = (state_q == ST_IDLE) && !m_tvalid_q && aresetn;
  assign s_hs          = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    m_tdata_d  = m_tdata_q;
    m_tvalid_d = m_tvalid_q;
    sdo_d      = sdo_q;
    csn_d      = csn_q;
    sclk_d     = sclk_q;
    busy_d     = busy_q;

    // Readback may be consumed in any state.
    if (m_tvalid_q && m_axis_tready) begin
      m_tvalid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        sclk_d = 1'b0;
        if (s_hs) begin
          tx_d    = s_axis_tdata;
          sdo_d   = s_axis_tdata[DATA_WIDTH-1];
          csn_d   = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!sclk_q) begin
            // Rising SCLK: the ADC has had a full low half-period to present
            // its bit, so it is captured here, MSB first.
            sclk_d = 1'b1;
            rx_d   = {rx_q[DATA_WIDTH-2:0], spi_sdi};
          end else begin
            // Falling SCLK: advance SDO, which stays stable across the next
            // rising edge.
            sclk_d = 1'b0;
            if (bit_q == BIT_LAST) begin
              sdo_d   = 1'b0;
              state_d = ST_HOLD;
            end else begin
              bit_d = bit_q + BIT_W'(1);
              tx_d  = {tx_q[DATA_WIDTH-2:0], 1'b0};
              sdo_d = tx_q[DATA_WIDTH-2];
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d      = '0;
          csn_d      = 1'b1;
          m_tdata_d  = rx_q;
          m_tvalid_d = 1'b1;
          state_d    = ST_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_GAP: begin
        if (cnt_q == IDLE_LAST) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        // Unreachable encodings recover to a quiet bus.
        state_d = ST_IDLE;
        cnt_d   = '0;
        csn_d   = 1'b1;
        sclk_d  = 1'b0;
        sdo_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      sdo_q      <= 1'b0;
      csn_q      <= 1'b1;
      sclk_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      m_tdata_q  <= m_tdata_d;
      m_tvalid_q <= m_tvalid_d;
      sdo_q      <= sdo_d;
      csn_q      <= csn_d;
      sclk_q     <= sclk_d;
      busy_q     <= busy_d;
    end
  end

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign spi_sdo       = sdo_q;
  assign spi_csn       = csn_q;
  assign spi_clk       = sclk_q;
  assign busy          = busy_q;

endmodule
